// File: rtl/uart_pkg.sv
// Shared UART line levels, frame geometry and the echo-initiator state encoding.
package uart_pkg;

    localparam int   CLK_HZ               = 25_000_000;
    localparam int   BAUD                 = 115_200;
    localparam int   DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_BIT,
        ST_DATA_BITS,
        ST_STOP_BIT,
        ST_WAIT_ECHO,
        ST_GAP
    } echo_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/echo_tx_shifter.sv
// Bit-timed UART frame serialiser: parallel load, start bit, 8 data bits LSB first, stop bit.
module echo_tx_shifter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_bit_done,
    output logic       o_frame_done,
    output logic [3:0] o_bit_idx
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_IDX = 4'(UART_DATA_BITS + 1);

    logic [9:0]    frame_q, frame_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          tx_q, tx_d;

    assign o_bit_done   = active_q && (cnt_q == CNT_MAX);
    assign o_frame_done = o_bit_done && (idx_q == LAST_IDX);
    assign o_bit_idx    = idx_q;
    assign o_tx         = tx_q;

    // frame_q[0] always holds the bit currently on the line
    always_comb begin
        frame_d  = frame_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        tx_d     = tx_q;
        if (i_load) begin
            frame_d  = {UART_STOP_LVL, i_data, UART_START_LVL};
            idx_d    = 4'd0;
            cnt_d    = '0;
            active_d = 1'b1;
            tx_d     = UART_START_LVL;
        end else if (active_q) begin
            if (o_bit_done) begin
                cnt_d = '0;
                if (o_frame_done) begin
                    active_d = 1'b0;
                    tx_d     = UART_IDLE_LVL;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    frame_d = {UART_IDLE_LVL, frame_q[9:1]};
                    tx_d    = frame_q[1];
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_q  <= '1;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            tx_q     <= UART_IDLE_LVL;
        end else begin
            frame_q  <= frame_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/uart_echo_initiator.sv
// Host-side echo tester: sends a run of incrementing bytes, checks each echo, keeps pass/error/timeout status.
module uart_echo_initiator
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int         NUM_BYTES    = 16,
    parameter logic [7:0] START_BYTE   = 8'h00,
    parameter int         TIMEOUT_CLKS = 6510
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_TX_Serial,
    output logic       o_Busy,
    output logic [7:0] o_Last_Sent,
    output logic [7:0] o_Pass_Count,
    output logic [7:0] o_Err_Count,
    output logic       o_Timeout,
    output logic       o_Done
);

    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CLKS - 1);
    localparam int            GW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [GW-1:0] GAP_MAX  = GW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_BYTES - 1);

    echo_state_e   state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    exp_q, exp_d;
    logic [7:0]    pass_q, pass_d;
    logic [7:0]    err_q, err_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic       load;
    logic [7:0] load_byte;
    logic       bit_done;
    logic       frame_done;
    logic [3:0] bit_idx;

    echo_tx_shifter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk       (i_Clock),
        .i_rst_n     (i_Rst_L),
        .i_load      (load),
        .i_data      (load_byte),
        .o_tx        (o_TX_Serial),
        .o_bit_done  (bit_done),
        .o_frame_done(frame_done),
        .o_bit_idx   (bit_idx)
    );

    // exp_q is both the byte on the wire and the value the echo must match
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        exp_d      = exp_q;
        pass_d     = pass_q;
        err_d      = err_q;
        tmo_flag_d = tmo_flag_q;
        tmo_cnt_d  = tmo_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        load_byte  = exp_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    pass_d     = 8'd0;
                    err_d      = 8'd0;
                    tmo_flag_d = 1'b0;
                    idx_d      = 8'd0;
                    exp_d      = START_BYTE;
                    load       = 1'b1;
                    load_byte  = START_BYTE;
                    busy_d     = 1'b1;
                    state_d    = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (bit_done) state_d = ST_DATA_BITS;
            end
            ST_DATA_BITS: begin
                if (bit_done && (bit_idx == 4'(UART_DATA_BITS))) state_d = ST_STOP_BIT;
            end
            ST_STOP_BIT: begin
                if (frame_done) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_ECHO;
                end
            end
            ST_WAIT_ECHO: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // an echo arriving on the expiry cycle takes priority over the timeout
                if (i_RX_DV) begin
                    if (i_RX_Byte == exp_q) pass_d = sat_inc8(pass_q);
                    else                    err_d  = sat_inc8(err_q);
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    err_d      = sat_inc8(err_q);
                    tmo_flag_d = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_MAX) begin
                    gap_cnt_d = '0;
                    if (idx_q < LAST_IDX) begin
                        idx_d     = idx_q + 8'd1;
                        exp_d     = exp_q + 8'd1;
                        load      = 1'b1;
                        load_byte = exp_q + 8'd1;
                        state_d   = ST_START_BIT;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            idx_q      <= 8'd0;
            exp_q      <= START_BYTE;
            pass_q     <= 8'd0;
            err_q      <= 8'd0;
            tmo_flag_q <= 1'b0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            exp_q      <= exp_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_Busy       = busy_q;
    assign o_Last_Sent  = exp_q;
    assign o_Pass_Count = pass_q;
    assign o_Err_Count  = err_q;
    assign o_Timeout    = tmo_flag_q;
    assign o_Done       = done_q;

endmodule

// File: tb/tb_uart_echo_initiator.sv
// Directed bench for uart_echo_initiator: decodes the TX line, plays the echo responder, checks status.
module tb_uart_echo_initiator;

    localparam int         CPB = 4;
    localparam int         NB  = 3;
    localparam logic [7:0] SB  = 8'hFE;
    localparam int         TMO = 100;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       start   = 1'b0;
    logic       rx_dv   = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       o_TX_Serial, o_Busy, o_Timeout, o_Done;
    logic [7:0] o_Last_Sent, o_Pass_Count, o_Err_Count;

    always #5 clk = ~clk;

    uart_echo_initiator #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (NB),
        .START_BYTE  (SB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_Start     (start),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .o_TX_Serial (o_TX_Serial),
        .o_Busy      (o_Busy),
        .o_Last_Sent (o_Last_Sent),
        .o_Pass_Count(o_Pass_Count),
        .o_Err_Count (o_Err_Count),
        .o_Timeout   (o_Timeout),
        .o_Done      (o_Done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [2:0] silent;
        logic [2:0] corrupt;
        logic [2:0] collide;
        logic       stray;
        logic [7:0] bad;
        int         pass;
        int         err;
        logic       tmo;
    } vec_t;

    task automatic check_reset_values(input string tag);
        chk({tag, " tx"},    32'(o_TX_Serial),  32'd1);
        chk({tag, " busy"},  32'(o_Busy),       32'd0);
        chk({tag, " done"},  32'(o_Done),       32'd0);
        chk({tag, " tmo"},   32'(o_Timeout),    32'd0);
        chk({tag, " last"},  32'(o_Last_Sent),  32'(SB));
        chk({tag, " pass"},  32'(o_Pass_Count), 32'd0);
        chk({tag, " err"},   32'(o_Err_Count),  32'd0);
    endtask

    // One full run: checks every line bit, plays the responder, checks echo-wait length and final status.
    task automatic run(input vec_t v);
        logic [7:0] exp_b;
        logic [7:0] rx;
        logic [9:0] line;
        logic       bit_ok;
        logic       done_seen;
        int         k;
        int         want_k;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("%s busy_at_start", v.name), 32'(o_Busy), 32'd1);
        for (int b = 0; b < NB; b++) begin
            exp_b = SB + 8'(b);
            line  = {1'b1, exp_b, 1'b0};
            rx    = 8'h00;
            chk($sformatf("%s b%0d last_sent", v.name, b), 32'(o_Last_Sent), 32'(exp_b));
            for (int i = 0; i < 10; i++) begin
                bit_ok = 1'b1;
                for (int j = 0; j < CPB; j++) begin
                    if (i != 0 || j != 0) tick();
                    if (o_TX_Serial !== line[i]) bit_ok = 1'b0;
                    if (j == CPB / 2 && i >= 1 && i <= 8) rx[i-1] = o_TX_Serial;
                    if (v.stray && b == 0 && i == 3) begin
                        if (j == 1) begin
                            start   = 1'b1;
                            rx_dv   = 1'b1;
                            rx_byte = exp_b;
                        end else if (j == 2) begin
                            start = 1'b0;
                            rx_dv = 1'b0;
                        end
                    end
                end
                chk($sformatf("%s b%0d line_bit%0d", v.name, b, i), 32'(bit_ok), 32'd1);
            end
            chk($sformatf("%s b%0d decoded", v.name, b), 32'(rx), 32'(exp_b));
            k         = 0;
            done_seen = 1'b0;
            while (k < 200) begin
                tick();
                k++;
                if (k == 10 || k == 101) rx_dv = 1'b0;
                if (!v.silent[b] && !v.collide[b] && k == 9) begin
                    rx_dv   = 1'b1;
                    rx_byte = v.corrupt[b] ? v.bad : rx;
                end
                if (v.collide[b] && k == 100) begin
                    rx_dv   = 1'b1;
                    rx_byte = rx;
                end
                if (o_Done === 1'b1) begin
                    done_seen = 1'b1;
                    break;
                end
                if (o_TX_Serial === 1'b0) break;
            end
            rx_dv  = 1'b0;
            want_k = (v.silent[b] || v.collide[b]) ? TMO + CPB + 1 : 9 + CPB + 1;
            chk($sformatf("%s b%0d echo_wait_plus_gap", v.name, b), 32'(k), 32'(want_k));
            chk($sformatf("%s b%0d done_flag", v.name, b), 32'(done_seen), 32'(b == NB - 1));
        end
        chk($sformatf("%s pass", v.name), 32'(o_Pass_Count), 32'(v.pass));
        chk($sformatf("%s err", v.name),  32'(o_Err_Count),  32'(v.err));
        chk($sformatf("%s tmo", v.name),  32'(o_Timeout),    32'(v.tmo));
        chk($sformatf("%s busy_at_done", v.name), 32'(o_Busy), 32'd0);
        tick();
        chk($sformatf("%s done_one_cycle", v.name), 32'(o_Done), 32'd0);
        chk($sformatf("%s pass_held", v.name), 32'(o_Pass_Count), 32'(v.pass));
        chk($sformatf("%s tmo_held", v.name), 32'(o_Timeout), 32'(v.tmo));
        repeat (3) tick();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{name: "loopback",  silent: 3'b000, corrupt: 3'b000, collide: 3'b000, stray: 1'b0,
                    bad: 8'h00, pass: 3, err: 0, tmo: 1'b0};
        vecs[1] = '{name: "corrupt2",  silent: 3'b000, corrupt: 3'b010, collide: 3'b000, stray: 1'b0,
                    bad: 8'h7F, pass: 2, err: 1, tmo: 1'b0};
        vecs[2] = '{name: "silent",    silent: 3'b111, corrupt: 3'b000, collide: 3'b000, stray: 1'b0,
                    bad: 8'h00, pass: 0, err: 3, tmo: 1'b1};
        vecs[3] = '{name: "collision", silent: 3'b000, corrupt: 3'b000, collide: 3'b001, stray: 1'b1,
                    bad: 8'h00, pass: 3, err: 0, tmo: 1'b0};
        vecs[4] = '{name: "mixed",     silent: 3'b100, corrupt: 3'b001, collide: 3'b000, stray: 1'b0,
                    bad: 8'h00, pass: 1, err: 2, tmo: 1'b1};

        #2 rst_n = 1'b0;
        #1 check_reset_values("por");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) tick();
        check_reset_values("idle");

        for (int t = 0; t < 5; t++) run(vecs[t]);

        // Reset mid-frame: line is low in data bit 0 of 8'hFE when reset hits between edges.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("midrst tx_before", 32'(o_TX_Serial), 32'd0);
        chk("midrst busy_before", 32'(o_Busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) tick();
        check_reset_values("midrst_idle");
        run(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
